// File: rtl/nbt_sram_ctrl.sv
// Request-stream initiator for an x36 NBT synchronous SRAM.
// Every accepted request becomes one pin cycle; ZZ sleep is entered after an idle period.
module nbt_sram_ctrl #(
  parameter int A_BITS      = 19,
  parameter int FLOW_THRU   = 0,
  parameter int IDLE_CYCLES = 64,
  parameter int WAKE_CYCLES = 4
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [A_BITS-1:0] req_addr,
  input  logic [3:0]        req_be,
  input  logic [35:0]       req_wdata,
  output logic              rsp_valid,
  output logic [35:0]       rsp_rdata,
  output logic [A_BITS-1:0] sram_a,
  output logic [3:0]        sram_nbw,
  output logic              sram_nw,
  output logic              sram_ne1,
  output logic              sram_e2,
  output logic              sram_ne3,
  output logic              sram_ng,
  output logic              sram_adv,
  output logic              sram_ncke,
  output logic              sram_zz,
  output logic              sram_nft,
  output logic              sram_nlbo,
  output logic [35:0]       sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [35:0]       sram_dq_i
);
  // Handshake: a request transfers on an HCLK rise where req_valid && req_ready;
  // req_valid/fields must stay stable until then. rsp_valid is a one-cycle pulse with no back-pressure.

  localparam int L  = (FLOW_THRU != 0) ? 1 : 2;
  localparam int IW = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;
  localparam int WW = $clog2(WAKE_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_CYCLES);
  localparam logic [WW-1:0] WAKE_LAST = WW'((WAKE_CYCLES > 1) ? WAKE_CYCLES - 2 : 0);

  typedef enum logic [1:0] {RUN = 2'd0, SLEEP = 2'd1, WAKE = 2'd2} state_t;

  state_t        state;
  logic [IW-1:0] idleCnt;
  logic [WW-1:0] wakeCnt;
  logic [L:0]    opValid;
  logic [L:0]    opWrite;
  logic [35:0]   opData [L];
  logic          accept;
  logic          pipeEmpty;

  assign accept    = req_valid & req_ready;
  assign pipeEmpty = ~|opValid;

  assign sram_e2   = 1'b1;
  assign sram_ne3  = 1'b0;
  assign sram_adv  = 1'b0;
  assign sram_nft  = (FLOW_THRU == 0);
  assign sram_nlbo = 1'b1;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state      <= RUN;
      idleCnt    <= '0;
      wakeCnt    <= '0;
      opValid    <= '0;
      opWrite    <= '0;
      for (int i = 0; i < L; i++) opData[i] <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      sram_a     <= '0;
      sram_nbw   <= 4'hF;
      sram_nw    <= 1'b1;
      sram_ne1   <= 1'b1;
      sram_ng    <= 1'b1;
      sram_ncke  <= 1'b0;
      sram_zz    <= 1'b0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
    end else begin
      // Stage i holds the op issued i cycles ago; stage L-1 drives write data, stage L captures reads.
      opValid   <= {opValid[L-1:0], accept};
      opWrite   <= {opWrite[L-1:0], req_write};
      opData[0] <= req_wdata;
      for (int i = 1; i < L; i++) opData[i] <= opData[i-1];

      sram_dq_oe <= opValid[L-1] & opWrite[L-1];
      sram_dq_o  <= opData[L-1];
      rsp_valid  <= opValid[L] & ~opWrite[L];
      if (opValid[L] && !opWrite[L]) rsp_rdata <= sram_dq_i;

      if (accept) sram_a <= req_addr;
      sram_ne1 <= ~accept;
      sram_nw  <= ~(accept & req_write);
      sram_nbw <= (accept && req_write) ? ~req_be : 4'hF;

      case (state)
        RUN: begin
          if (accept)                   idleCnt <= '0;
          else if (idleCnt != IDLE_MAX) idleCnt <= idleCnt + 1'b1;
          // An accept on the threshold edge keeps the controller awake.
          if (IDLE_CYCLES != 0 && !accept && idleCnt == IDLE_MAX && pipeEmpty) begin
            state     <= SLEEP;
            req_ready <= 1'b0;
            sram_zz   <= 1'b1;
            sram_ncke <= 1'b1;
            sram_ng   <= 1'b1;
          end else begin
            req_ready <= 1'b1;
            sram_ng   <= 1'b0;
          end
        end
        SLEEP: begin
          if (req_valid) begin
            sram_zz   <= 1'b0;
            sram_ncke <= 1'b0;
            wakeCnt   <= '0;
            if (WAKE_CYCLES <= 1) begin
              state     <= RUN;
              req_ready <= 1'b1;
              sram_ng   <= 1'b0;
              idleCnt   <= '0;
            end else begin
              state <= WAKE;
            end
          end
        end
        WAKE: begin
          if (wakeCnt == WAKE_LAST) begin
            state     <= RUN;
            req_ready <= 1'b1;
            sram_ng   <= 1'b0;
            idleCnt   <= '0;
          end else begin
            wakeCnt <= wakeCnt + 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule
